// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the shared program RAM after bus
// arbitration, and presents each fetched byte to the decoder until it is accepted.
module instr_fetch #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [3:0]        ir_opcode,
    output logic [3:0]        ir_operand,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              halted,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RD   = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              accept;
    logic              is_halt_op;

    // Handshake: the decoder takes the IR on any cycle where ir_valid and
    // ir_ready are both high; ir_valid never drops and the IR never changes
    // until that happens. jump_en/jump_addr only matter on that cycle.
    assign accept     = ir_valid & ir_ready;
    assign is_halt_op = (ir[DATA_W-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (bus_gnt) state_nxt = S_RD;
            S_RD:    state_nxt = S_HOLD;
            S_HOLD: begin
                if (accept) begin
                    if (is_halt_op) state_nxt = S_HALT;
                    else            state_nxt = S_REQ;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_REQ;
        endcase
    end

    // A jump only redirects the PC for non-HALT instructions; HALT freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            ir    <= '0;
            ir_pc <= '0;
        end else if (state == S_RD) begin
            ir    <= ram_data;
            ir_pc <= pc;
            pc    <= pc + ADDR_W'(1);
        end else if (accept && !is_halt_op && jump_en) begin
            pc <= jump_addr;
        end
    end

    // bus_req is gated by rst_n so it reads low while reset is held, even
    // though the state register already sits in S_REQ.
    assign bus_req     = rst_n & ((state == S_REQ) | (state == S_RD));
    assign ram_read_en = rst_n & (state == S_RD);
    assign ram_address = pc;
    assign ir_valid    = (state == S_HOLD);
    assign halted      = (state == S_HALT);
    assign ir_opcode   = ir[DATA_W-1 -: 4];
    assign ir_operand  = ir[3:0];
    assign state_dbg   = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table-driven program walk, reset/halt sequences and a
// randomized phase checked against a PC/RAM reference model.
module tb_instr_fetch;

    logic       clk;
    logic       rst_n;
    logic       bus_req;
    logic       bus_gnt;
    logic [3:0] ram_address;
    logic       ram_read_en;
    logic [7:0] ram_data;
    logic       ir_valid;
    logic       ir_ready;
    logic [3:0] ir_opcode;
    logic [3:0] ir_operand;
    logic [3:0] ir_pc;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       halted;
    logic [1:0] state_dbg;

    logic [7:0]  ram [16];
    logic [3:0]  m_pc;
    logic [11:0] exp_q [$];
    int          total;
    int          bad;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .ram_address (ram_address),
        .ram_read_en (ram_read_en),
        .ram_data    (ram_data),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_opcode   (ir_opcode),
        .ir_operand  (ir_operand),
        .ir_pc       (ir_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    assign ram_data = ram_read_en ? ram[ram_address] : 8'h00;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus_gnt  = 1'b0;
        ir_ready = 1'b0;
        jump_en  = 1'b0;
        @(negedge clk);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_rd_en", ram_read_en, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_ir", {ir_opcode, ir_operand}, 8'h00);
        chk("rst_ir_pc", ir_pc, 4'h0);
        chk("rst_addr", ram_address, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_pc = 4'h0;
        exp_q.delete();
    endtask

    // driver: one complete fetch from REQ through accept
    task automatic fetch_one(input int gd, input int st, input bit jmp, input logic [3:0] ja,
                             input bit use_tab, input logic [7:0] t_ir, input logic [3:0] t_pc,
                             output bit hit_halt);
        logic [11:0] e;
        logic [3:0]  nxt;
        chk("req_bus_req", bus_req, 1'b1);
        chk("req_rd_en", ram_read_en, 1'b0);
        chk("req_addr", ram_address, m_pc);
        for (int i = 0; i < gd; i++) begin
            bus_gnt = 1'b0;
            tick();
            chk("wait_bus_req", bus_req, 1'b1);
            chk("wait_rd_en", ram_read_en, 1'b0);
            chk("wait_addr", ram_address, m_pc);
        end
        bus_gnt = 1'b1;
        tick();
        chk("rd_en", ram_read_en, 1'b1);
        chk("rd_bus_req", bus_req, 1'b1);
        chk("rd_addr", ram_address, m_pc);
        chk("rd_valid", ir_valid, 1'b0);
        exp_q.push_back({m_pc, ram[m_pc]});
        bus_gnt = 1'($urandom_range(0, 1));
        tick();
        bus_gnt = 1'b0;
        e   = exp_q.pop_front();
        nxt = m_pc + 4'd1;
        chk("hold_valid", ir_valid, 1'b1);
        chk("hold_opcode", ir_opcode, e[7:4]);
        chk("hold_operand", ir_operand, e[3:0]);
        chk("hold_ir_pc", ir_pc, e[11:8]);
        chk("hold_pc_next", ram_address, nxt);
        chk("hold_rd_en", ram_read_en, 1'b0);
        if (use_tab) begin
            chk("tab_ir", {ir_opcode, ir_operand}, t_ir);
            chk("tab_pc", ir_pc, t_pc);
        end
        for (int i = 0; i < st; i++) begin
            ir_ready  = 1'b0;
            jump_en   = 1'b1;
            jump_addr = 4'($urandom_range(0, 15));
            bus_gnt   = 1'($urandom_range(0, 1));
            tick();
            chk("stall_valid", ir_valid, 1'b1);
            chk("stall_ir", {ir_opcode, ir_operand}, e[7:0]);
            chk("stall_rd_en", ram_read_en, 1'b0);
            chk("stall_addr", ram_address, nxt);
        end
        ir_ready  = 1'b1;
        jump_en   = jmp;
        jump_addr = ja;
        bus_gnt   = 1'b0;
        tick();
        ir_ready = 1'b0;
        jump_en  = 1'b0;
        if (e[7:4] == 4'h0) begin
            hit_halt = 1'b1;
            chk("halt_flag", halted, 1'b1);
            chk("halt_bus_req", bus_req, 1'b0);
            chk("halt_valid", ir_valid, 1'b0);
            chk("halt_rd_en", ram_read_en, 1'b0);
        end else begin
            hit_halt = 1'b0;
            m_pc = jmp ? ja : nxt;
            chk("acc_halted", halted, 1'b0);
            chk("acc_valid", ir_valid, 1'b0);
            chk("acc_addr", ram_address, m_pc);
        end
    endtask

    typedef struct {
        int         gd;
        int         st;
        bit         jmp;
        logic [3:0] ja;
        logic [7:0] ir;
        logic [3:0] pc;
        bit         halt;
    } vec_t;

    vec_t tab [10];

    initial begin
        bit hb;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus_gnt   = 1'b0;
        ir_ready  = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 4'h0;
        m_pc      = 4'h0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h50 | 8'(i);
        ram[0]  = 8'h2E;
        ram[1]  = 8'h1F;
        ram[2]  = 8'h94;
        ram[3]  = 8'hB5;
        ram[4]  = 8'hA2;
        ram[7]  = 8'h00;
        ram[15] = 8'h1F;

        //            gd st jmp ja     ir     pc     halt
        tab[0] = '{0, 0, 1'b0, 4'd0,  8'h2E, 4'd0,  1'b0};
        tab[1] = '{0, 0, 1'b0, 4'd0,  8'h1F, 4'd1,  1'b0};
        tab[2] = '{0, 0, 1'b0, 4'd0,  8'h94, 4'd2,  1'b0};
        tab[3] = '{0, 0, 1'b0, 4'd0,  8'hB5, 4'd3,  1'b0};
        tab[4] = '{0, 0, 1'b1, 4'd2,  8'hA2, 4'd4,  1'b0};
        tab[5] = '{5, 0, 1'b0, 4'd0,  8'h94, 4'd2,  1'b0};
        tab[6] = '{0, 4, 1'b1, 4'd15, 8'hB5, 4'd3,  1'b0};
        tab[7] = '{0, 0, 1'b0, 4'd0,  8'h1F, 4'd15, 1'b0};
        tab[8] = '{0, 0, 1'b1, 4'd7,  8'h2E, 4'd0,  1'b0};
        tab[9] = '{0, 0, 1'b0, 4'd0,  8'h00, 4'd7,  1'b1};

        do_reset();
        for (int k = 0; k < 10; k++) begin
            fetch_one(tab[k].gd, tab[k].st, tab[k].jmp, tab[k].ja, 1'b1, tab[k].ir, tab[k].pc, hb);
            chk("tab_halt", hb, tab[k].halt);
        end

        // halted is sticky whatever the grant/ready inputs do
        for (int i = 0; i < 5; i++) begin
            bus_gnt  = 1'b1;
            ir_ready = 1'b1;
            jump_en  = 1'b1;
            tick();
            chk("halt_stay", halted, 1'b1);
            chk("halt_stay_req", bus_req, 1'b0);
            chk("halt_stay_rd", ram_read_en, 1'b0);
        end

        // reset asserted in the middle of a RAM read
        do_reset();
        bus_gnt = 1'b1;
        tick();
        chk("mid_rd_en", ram_read_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", ram_read_en, 1'b0);
        chk("mid_rst_bus_req", bus_req, 1'b0);
        chk("mid_rst_valid", ir_valid, 1'b0);
        chk("mid_rst_addr", ram_address, 4'h0);
        bus_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_pc = 4'h0;
        exp_q.delete();
        fetch_one(0, 0, 1'b0, 4'h0, 1'b1, 8'h2E, 4'h0, hb);

        // randomized program and handshake timing
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 60; n++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 1'b0, 8'h00, 4'h0, hb);
            if (hb) do_reset();
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
